// File: rtl/riscv_alu_issue_pkg.sv
// Shared constants for the RV32I ALU issue stage: datapath width, ALU control
// codes, opcodes, branch funct3 codes and the issue-slot record.
package riscv_alu_issue_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        alu_ctrl_e       alu_ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd;
        logic            wen;
        logic [2:0]      funct3;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            br_inv;
        logic            jump;
        logic            illegal;
    } issue_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate generator: forms every sign-extended RV32I immediate format from
// the instruction word (the opcode bits play no part).
module riscv_imm_gen
    import riscv_alu_issue_pkg::*;
(
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/riscv_alu_issue.sv
// ID->EX issue stage: decodes an RV32I instruction into ALU operands/control
// and holds it in a single registered slot with valid/ready and flush.
module riscv_alu_issue
    import riscv_alu_issue_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [31:0]     i_id_instr,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic            i_flush,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [4:0]      o_alu_ctrl,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_wen,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_mem_rd,
    output logic            o_ex_mem_wr,
    output logic            o_ex_branch,
    output logic            o_ex_br_inv,
    output logic            o_ex_jump,
    output logic            o_ex_illegal
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic            dec_wen_s;
    logic            accept_s;
    issue_t          dec_s;
    issue_t          slot_r;
    logic            valid_r;

    assign opcode_s = i_id_instr[6:0];
    assign funct3_s = i_id_instr[14:12];
    assign funct7_s = i_id_instr[31:25];

    riscv_imm_gen u_imm_gen (
        .instr (i_id_instr[31:7]),
        .imm_i (imm_i_s),
        .imm_s (imm_s_s),
        .imm_b (imm_b_s),
        .imm_u (imm_u_s),
        .imm_j (imm_j_s)
    );

    // Decode the offered instruction into the next slot contents.
    always_comb begin
        dec_s          = '0;
        dec_wen_s      = 1'b0;
        dec_s.alu_ctrl = ALU_ADD;
        dec_s.pc       = i_id_pc;
        dec_s.rs2_data = i_id_rs2_data;
        dec_s.rd       = i_id_instr[11:7];
        dec_s.funct3   = funct3_s;
        case (opcode_s)
            OPC_OP, OPC_OP_IMM: begin
                dec_wen_s   = 1'b1;
                dec_s.alu_a = i_id_rs1_data;
                if (opcode_s == OPC_OP) begin
                    dec_s.alu_b = i_id_rs2_data;
                end else begin
                    dec_s.alu_b = imm_i_s;
                    dec_s.imm   = imm_i_s;
                end
                case (funct3_s)
                    3'b000: dec_s.alu_ctrl = (opcode_s == OPC_OP && funct7_s[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: dec_s.alu_ctrl = ALU_SLL;
                    3'b010: dec_s.alu_ctrl = ALU_SLT;
                    3'b011: dec_s.alu_ctrl = ALU_SLTU;
                    3'b100: dec_s.alu_ctrl = ALU_XOR;
                    3'b101: dec_s.alu_ctrl = funct7_s[5] ? ALU_SRA : ALU_SRL;
                    3'b110: dec_s.alu_ctrl = ALU_OR;
                    3'b111: dec_s.alu_ctrl = ALU_AND;
                    default: dec_s.alu_ctrl = ALU_ADD;
                endcase
                // Immediate forms only check funct7 on shifts; shamt is the low five bits.
                if (opcode_s == OPC_OP) begin
                    dec_s.illegal = !((funct7_s == 7'h00) ||
                                      (funct7_s == 7'h20 && (funct3_s == 3'b000 || funct3_s == 3'b101)));
                end else if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    dec_s.alu_b   = {27'd0, imm_i_s[4:0]};
                    dec_s.illegal = !((funct7_s == 7'h00) || (funct7_s == 7'h20 && funct3_s == 3'b101));
                end else begin
                    dec_s.illegal = 1'b0;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_wen_s   = 1'b1;
                dec_s.alu_a = (opcode_s == OPC_AUIPC) ? i_id_pc : {XLEN{1'b0}};
                dec_s.alu_b = imm_u_s;
                dec_s.imm   = imm_u_s;
            end
            OPC_LOAD: begin
                dec_wen_s    = 1'b1;
                dec_s.alu_a  = i_id_rs1_data;
                dec_s.alu_b  = imm_i_s;
                dec_s.imm    = imm_i_s;
                dec_s.mem_rd = 1'b1;
            end
            OPC_STORE: begin
                dec_s.alu_a  = i_id_rs1_data;
                dec_s.alu_b  = imm_s_s;
                dec_s.imm    = imm_s_s;
                dec_s.mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.alu_a  = i_id_rs1_data;
                dec_s.alu_b  = i_id_rs2_data;
                dec_s.imm    = imm_b_s;
                dec_s.branch = 1'b1;
                case (funct3_s)
                    F3_BEQ:  begin dec_s.alu_ctrl = ALU_SUB;  dec_s.br_inv = 1'b0; end
                    F3_BNE:  begin dec_s.alu_ctrl = ALU_SUB;  dec_s.br_inv = 1'b1; end
                    F3_BLT:  begin dec_s.alu_ctrl = ALU_SLT;  dec_s.br_inv = 1'b1; end
                    F3_BGE:  begin dec_s.alu_ctrl = ALU_SLT;  dec_s.br_inv = 1'b0; end
                    F3_BLTU: begin dec_s.alu_ctrl = ALU_SLTU; dec_s.br_inv = 1'b1; end
                    F3_BGEU: begin dec_s.alu_ctrl = ALU_SLTU; dec_s.br_inv = 1'b0; end
                    default: dec_s.illegal = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_wen_s   = 1'b1;
                dec_s.alu_a = i_id_pc;
                dec_s.alu_b = 32'd4;
                dec_s.imm   = (opcode_s == OPC_JAL) ? imm_j_s : imm_i_s;
                dec_s.jump  = 1'b1;
            end
            default: dec_s.illegal = 1'b1;
        endcase
        // Illegal encodings still issue, but with every side effect suppressed.
        if (dec_s.illegal) begin
            dec_wen_s      = 1'b0;
            dec_s.alu_ctrl = ALU_ADD;
            dec_s.mem_rd   = 1'b0;
            dec_s.mem_wr   = 1'b0;
            dec_s.branch   = 1'b0;
            dec_s.br_inv   = 1'b0;
            dec_s.jump     = 1'b0;
        end else begin
            dec_s.illegal  = 1'b0;
        end
        dec_s.wen = dec_wen_s && (dec_s.rd != 5'd0);
    end

    assign o_id_ready = !valid_r || i_ex_ready;
    assign accept_s   = i_id_valid && o_id_ready;

    // Single issue slot: flush beats accept, accept refills, consume empties.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_r <= 1'b0;
            slot_r  <= '0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            slot_r  <= dec_s;
        end else if (i_ex_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign o_ex_valid    = valid_r;
    assign o_alu_a       = slot_r.alu_a;
    assign o_alu_b       = slot_r.alu_b;
    assign o_alu_ctrl    = slot_r.alu_ctrl;
    assign o_ex_imm      = slot_r.imm;
    assign o_ex_pc       = slot_r.pc;
    assign o_ex_rs2_data = slot_r.rs2_data;
    assign o_ex_rd       = slot_r.rd;
    assign o_ex_wen      = slot_r.wen;
    assign o_ex_funct3   = slot_r.funct3;
    assign o_ex_mem_rd   = slot_r.mem_rd;
    assign o_ex_mem_wr   = slot_r.mem_wr;
    assign o_ex_branch   = slot_r.branch;
    assign o_ex_br_inv   = slot_r.br_inv;
    assign o_ex_jump     = slot_r.jump;
    assign o_ex_illegal  = slot_r.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed self-checking bench for riscv_alu_issue with hand-encoded RV32I
// instructions and hand-computed expected outputs.
module tb_riscv_alu_issue;
    import riscv_alu_issue_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic [2:0]      ex_funct3;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic            ex_branch;
    logic            ex_br_inv;
    logic            ex_jump;
    logic            ex_illegal;

    int checks = 0;
    int errors = 0;

    riscv_alu_issue dut (
        .i_clk         (clk),
        .i_rstn        (rst_n),
        .i_id_valid    (id_valid),
        .o_id_ready    (id_ready),
        .i_id_instr    (id_instr),
        .i_id_pc       (id_pc),
        .i_id_rs1_data (id_rs1_data),
        .i_id_rs2_data (id_rs2_data),
        .i_flush       (flush),
        .o_ex_valid    (ex_valid),
        .i_ex_ready    (ex_ready),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_ctrl    (alu_ctrl),
        .o_ex_imm      (ex_imm),
        .o_ex_pc       (ex_pc),
        .o_ex_rs2_data (ex_rs2_data),
        .o_ex_rd       (ex_rd),
        .o_ex_wen      (ex_wen),
        .o_ex_funct3   (ex_funct3),
        .o_ex_mem_rd   (ex_mem_rd),
        .o_ex_mem_wr   (ex_mem_wr),
        .o_ex_branch   (ex_branch),
        .o_ex_br_inv   (ex_br_inv),
        .o_ex_jump     (ex_jump),
        .o_ex_illegal  (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        id_valid    = 1'b1;
        id_instr    = instr;
        id_pc       = pc;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
        step();
        id_valid    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; id_pc = 32'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        #12;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_ctrl",  32'(alu_ctrl), 32'(ALU_ADD));
        check("rst_a",     alu_a, 32'd0);
        check("rst_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2
        send(32'h002081B3, 32'h0000_0040, 32'd5, 32'd7);
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_a",     alu_a, 32'd5);
        check("add_b",     alu_b, 32'd7);
        check("add_ctrl",  32'(alu_ctrl), 32'(ALU_ADD));
        check("add_rd",    32'(ex_rd), 32'd3);
        check("add_wen",   32'(ex_wen), 32'd1);
        check("add_pc",    ex_pc, 32'h0000_0040);

        send(32'h402081B3, 32'd0, 32'd5, 32'd7);
        check("sub_ctrl",  32'(alu_ctrl), 32'(ALU_SUB));

        // srai x4,x1,3
        send(32'h4030D213, 32'd0, 32'hF000_0000, 32'd0);
        check("srai_b",    alu_b, 32'd3);
        check("srai_ctrl", 32'(alu_ctrl), 32'(ALU_SRA));
        check("srai_a",    alu_a, 32'hF000_0000);

        // mul encoding is not RV32I
        send(32'h022081B3, 32'd0, 32'd5, 32'd7);
        check("mul_illegal", 32'(ex_illegal), 32'd1);
        check("mul_valid",   32'(ex_valid), 32'd1);

        // lui x5,0xABCDE
        send(32'hABCDE2B7, 32'd0, 32'd9, 32'd9);
        check("lui_a",     alu_a, 32'd0);
        check("lui_b",     alu_b, 32'hABCDE000);
        check("lui_ill",   32'(ex_illegal), 32'd0);

        // sw x2,-4(x1)
        send(32'hFE20AE23, 32'd0, 32'd100, 32'h1234_5678);
        check("sw_imm",    ex_imm, 32'hFFFF_FFFC);
        check("sw_memwr",  32'(ex_mem_wr), 32'd1);
        check("sw_wen",    32'(ex_wen), 32'd0);
        check("sw_data",   ex_rs2_data, 32'h1234_5678);
        check("sw_funct3", 32'(ex_funct3), 32'd2);

        // jal x1,+8 at pc 0x100
        send(32'h008000EF, 32'h0000_0100, 32'd0, 32'd0);
        check("jal_a",     alu_a, 32'h0000_0100);
        check("jal_b",     alu_b, 32'd4);
        check("jal_jump",  32'(ex_jump), 32'd1);
        check("jal_imm",   ex_imm, 32'd8);

        // bge x1,x2,+8
        send(32'h0020D463, 32'd0, 32'd1, 32'd2);
        check("bge_ctrl",   32'(alu_ctrl), 32'(ALU_SLT));
        check("bge_inv",    32'(ex_br_inv), 32'd0);
        check("bge_branch", 32'(ex_branch), 32'd1);
        check("bge_wen",    32'(ex_wen), 32'd0);
        check("bge_imm",    ex_imm, 32'd8);

        // bne x1,x2,+8
        send(32'h00209463, 32'd0, 32'd1, 32'd2);
        check("bne_ctrl",  32'(alu_ctrl), 32'(ALU_SUB));
        check("bne_inv",   32'(ex_br_inv), 32'd1);

        // opcode 0x7F with rd=3
        send(32'h000001FF, 32'd0, 32'd1, 32'd2);
        check("opc7f_illegal", 32'(ex_illegal), 32'd1);
        check("opc7f_wen",     32'(ex_wen), 32'd0);
        check("opc7f_ctrl",    32'(alu_ctrl), 32'(ALU_ADD));

        // add x0,x1,x2
        send(32'h00208033, 32'd0, 32'd1, 32'd2);
        check("x0_wen",    32'(ex_wen), 32'd0);

        // Stall: slot holds add x3 while a sub is offered
        send(32'h002081B3, 32'd0, 32'd5, 32'd7);
        ex_ready    = 1'b0;
        id_valid    = 1'b1;
        id_instr    = 32'h402081B3;
        id_rs1_data = 32'd11;
        id_rs2_data = 32'd22;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(ex_valid), 32'd1);
            check("stall_ready", 32'(id_ready), 32'd0);
            check("stall_a",     alu_a, 32'd5);
            check("stall_ctrl",  32'(alu_ctrl), 32'(ALU_ADD));
        end
        ex_ready = 1'b1;
        step();
        check("unstall_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
        check("unstall_a",    alu_a, 32'd11);
        // Back-to-back addi x6,x1,i
        for (int i = 1; i <= 3; i++) begin
            id_instr = (32'(i) << 20) | 32'h0000_8313;
            step();
            check("b2b_valid", 32'(ex_valid), 32'd1);
            check("b2b_b",     alu_b, 32'(i));
        end

        // Flush wins over an offered beat
        flush    = 1'b1;
        id_instr = 32'h0090_8313;
        step();
        flush    = 1'b0;
        id_valid = 1'b0;
        check("flush_valid", 32'(ex_valid), 32'd0);
        step();
        check("flush_drop",  32'(ex_valid), 32'd0);

        // Asynchronous reset while a sub is held
        ex_ready = 1'b0;
        send(32'h402081B3, 32'd0, 32'd5, 32'd7);
        check("pre_rst_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_ctrl",  32'(alu_ctrl), 32'(ALU_ADD));
        check("arst_a",     alu_a, 32'd0);
        #3;
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
